// File: rtl/mem_row_streamer.sv
// mem_row_streamer: read-side sequencer for the single-ported row memory.
// It issues `count` consecutive reads starting at `base` and wrapping modulo
// DEPTH. Words returned by the memory are queued in a 2-entry buffer and
// presented as a valid/ready stream, with the final word of a run marked by
// out_last.
`timescale 1ns/1ps
module mem_row_streamer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    base,
  input  logic [AW:0]      count,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    rdaddress,
  output logic             rden,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);

  state_t           state_reg;
  logic [AW-1:0]    addr_reg;
  logic [AW:0]      remaining_reg;  // reads still to be issued
  logic [AW:0]      pending_reg;    // words not yet accepted by the consumer
  logic             busy_reg;
  logic             done_reg;
  logic             inflight_reg;   // a read was issued last cycle; q is valid now
  logic [1:0]       entries_reg;
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [WIDTH-1:0] slot_reg [2];

  logic             pop;
  logic [2:0]       occupancy;
  logic [AW-1:0]    addr_next;

  // Stream side: head of the buffer, last flag from the acceptance counter.
  assign out_valid = (entries_reg != 2'd0);
  assign out_data  = slot_reg[rd_ptr_reg];
  assign out_last  = out_valid & (pending_reg == CNT_ONE);
  assign pop       = out_valid & out_ready;

  // Issue a read only if the word can be guaranteed a buffer slot: words held
  // plus the one in flight, less any leaving this cycle, must stay below 2.
  assign occupancy = {1'b0, entries_reg} + {2'b00, inflight_reg};
  assign rden      = (state_reg == READ) && (occupancy < (3'd2 + {2'b00, pop}));
  assign rdaddress = addr_reg;
  assign addr_next = (addr_reg == LAST_ADDR) ? '0 : addr_reg + AW'(1);

  assign busy = busy_reg;
  assign done = done_reg;

  // Run sequencer: latches the request, walks the address range, waits for the
  // last word to be accepted, then pulses done for one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      pending_reg   <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      if (pop) begin
        pending_reg <= pending_reg - CNT_ONE;
      end
      unique case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            addr_reg      <= base;
            remaining_reg <= count;
            pending_reg   <= count;
            if (count == '0) begin
              state_reg <= FIN;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= READ;
              busy_reg  <= 1'b1;
            end
          end
        end
        READ: begin
          if (rden) begin
            addr_reg      <= addr_next;
            remaining_reg <= remaining_reg - CNT_ONE;
            if (remaining_reg == CNT_ONE) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && (pending_reg == CNT_ONE)) begin
            state_reg <= FIN;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        FIN: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Buffer bookkeeping: capture whenever a read was in flight, release on pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_reg <= 1'b0;
      entries_reg  <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
    end else begin
      inflight_reg <= rden;
      entries_reg  <= entries_reg + {1'b0, inflight_reg} - {1'b0, pop};
      if (inflight_reg) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      // Each slot loads q when it is the tail and the read data is arriving.
      always_ff @(posedge clock) begin
        if (reset) begin
          slot_reg[gi] <= '0;
        end else if (inflight_reg && (wr_ptr_reg == 1'(gi))) begin
          slot_reg[gi] <= q;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_mem_row_streamer.sv
// Directed testbench for mem_row_streamer with a registered-read memory model.
`timescale 1ns/1ps
module tb_mem_row_streamer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic             clock;
  logic             reset;
  logic             start;
  logic [AW-1:0]    base;
  logic [AW:0]      count;
  logic             busy;
  logic             done;
  logic [AW-1:0]    rdaddress;
  logic             rden;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  logic [WIDTH-1:0] mem [DEPTH];

  int n_checks;
  int n_err;

  mem_row_streamer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .base(base), .count(count),
    .busy(busy), .done(done), .rdaddress(rdaddress), .rden(rden), .q(q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: registered read, output held when rden is low.
  always @(posedge clock) begin
    if (rden) q <= mem[rdaddress];
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One run: start in cycle 0, then per cycle compare every output with a
  // model built from issued/accepted word counts.
  // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0,0,0,0 repeating.
  // exp_done > 0: required done cycle. dup_cycle > 0: pulse a second start then.
  // abort_at > 0: pulse reset once that many words have been accepted.
  task automatic run(input int b, input int n, input int mode, input int exp_done,
                     input int dup_cycle, input int abort_at);
    int  issued, accepted, cyc, outstanding, done_cyc;
    bit  prev_rden, exp_valid, exp_pop, exp_rden, s_rden, s_pop;
    issued = 0; accepted = 0; prev_rden = 0; done_cyc = -1;
    @(negedge clock);
    start = 1'b1; base = AW'(b); count = (AW+1)'(n);
    @(posedge clock);
    #1 start = 1'b0;
    for (cyc = 1; cyc < 400; cyc++) begin
      out_ready = (mode == 0) ? 1'b1 : (((cyc - 1) % 6) == 0);
      if (cyc == dup_cycle) begin
        start = 1'b1; base = AW'(b + 20); count = (AW+1)'(2);
      end
      @(negedge clock);
      outstanding = issued - accepted;
      exp_valid = (outstanding - int'(prev_rden)) > 0;
      exp_pop   = exp_valid && out_ready;
      exp_rden  = (issued < n) && ((outstanding - int'(exp_pop)) < 2);
      chk("outstanding_le_2", 32'(outstanding <= 2), 32'(1));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("rden", 32'(rden), 32'(exp_rden));
      if (rden && exp_rden) chk("rdaddress", 32'(rdaddress), 32'((b + issued) % DEPTH));
      if (out_valid && exp_valid) begin
        chk("out_data", 32'(out_data), 32'(mem[(b + accepted) % DEPTH]));
        chk("out_last", 32'(out_last), 32'(accepted == n - 1));
      end
      chk("busy", 32'(busy), 32'(accepted < n));
      chk("done", 32'(done), 32'(accepted == n));
      if (done) begin
        done_cyc = cyc;
        break;
      end
      s_rden = rden; s_pop = out_valid && out_ready;
      @(posedge clock);
      #1 start = 1'b0;
      if (s_rden) issued++;
      if (s_pop) accepted++;
      prev_rden = s_rden;
      if (abort_at > 0 && accepted == abort_at) begin
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_rden", 32'(rden), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_last", 32'(out_last), 32'(0));
        chk("rst_rdaddress", 32'(rdaddress), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        for (int k = 0; k < 5; k++) begin
          @(negedge clock);
          chk("abort_no_valid", 32'(out_valid), 32'(0));
          chk("abort_no_done", 32'(done), 32'(0));
          chk("abort_no_rden", 32'(rden), 32'(0));
        end
        $display("run base=%0d count=%0d aborted after %0d accepted", b, n, accepted);
        return;
      end
    end
    chk("done_seen", 32'(done_cyc > 0), 32'(1));
    if (exp_done > 0) chk("done_cycle", 32'(done_cyc), 32'(exp_done));
    chk("words_accepted", 32'(accepted), 32'(n));
    chk("words_issued", 32'(issued), 32'(n));
    @(posedge clock);
    @(negedge clock);
    chk("idle_done", 32'(done), 32'(0));
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_rden", 32'(rden), 32'(0));
    $display("run base=%0d count=%0d mode=%0d done_cycle=%0d accepted=%0d",
             b, n, mode, done_cyc, accepted);
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; base = '0; count = '0; out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 7 + 3);
    mem[10] = 8'hA1; mem[11] = 8'hB2; mem[12] = 8'hC3; mem[13] = 8'hD4;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_rden", 32'(rden), 32'(0));
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_out_last", 32'(out_last), 32'(0));
    chk("reset_rdaddress", 32'(rdaddress), 32'(0));
    chk("reset_out_data", 32'(out_data), 32'(0));
    $display("reset values checked");
    @(posedge clock);
    #1 reset = 1'b0;

    run(10, 4, 0, 7, 0, 0);     // basic run, A1..D4
    run(62, 4, 0, 7, 0, 0);     // address wrap 62,63,0,1
    run(5, 0, 0, 1, 0, 0);      // empty run: done in cycle 1 only
    run(0, 8, 1, -1, 0, 0);     // heavy backpressure
    run(30, 6, 0, 9, 2, 0);     // second start in READ is ignored
    run(40, 3, 0, 6, 0, 0);     // new run after done
    run(20, 8, 0, -1, 0, 3);    // reset after 3 of 8 accepted
    run(20, 8, 0, 11, 0, 0);    // restart after abort
    run(5, 64, 1, -1, 0, 0);    // full-depth run with backpressure
    run(5, 64, 0, 67, 0, 0);    // full-depth run at full rate

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
